// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, wait counter width.
// Latency: none (package only).
// Backpressure: not applicable.
package dmem_pkg;

    // RV32I load/store funct3 codes. Bits [1:0] give the size and bit 2 selects zero-extension.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store data-port bundle between the core (master) and the memory responder (slave).
// Latency: none (wiring only).
// Backpressure: valid/ready on both the request and the response channel.
// Signal names keep the responder's point of view, so _i means "into the responder".
interface dmem_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, load lane extract with
// sign/zero extension, and misalignment detection.
// Latency: combinational. Backpressure: none.
// Ports: i_addr (addr[1:0]), i_funct3, i_wdata, i_rword (RAM word) ->
//        o_be, o_wdata, o_rdata, o_err.
// Build option DMEM_MISALIGN_ERR_EN: when defined, o_err flags misaligned half/word
// accesses; otherwise o_err is 0 and the low address bits are simply ignored.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);
    logic       w_is_byte;
    logic       w_is_half;
    logic       w_zext;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    assign w_is_byte = (i_funct3[1:0] == F3_B[1:0]);
    assign w_is_half = (i_funct3[1:0] == F3_H[1:0]);
    assign w_zext    = i_funct3[2];

    always_comb begin
        w_byte = i_rword[7:0];
        case (i_addr)
            2'd0: w_byte = i_rword[7:0];
            2'd1: w_byte = i_rword[15:8];
            2'd2: w_byte = i_rword[23:16];
            2'd3: w_byte = i_rword[31:24];
            default: w_byte = i_rword[7:0];
        endcase
    end

    // Half lane is picked by addr[1] only; addr[0] never moves the lane.
    assign w_half = i_addr[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
        if (w_is_byte) begin
            o_be    = 4'b0001 << i_addr;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{~w_zext & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{~w_zext & w_half[15]}}, w_half};
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign o_err = (w_is_half & i_addr[0]) | (~w_is_byte & ~w_is_half & (|i_addr));
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: one load/store at a time, serviced from an internal word RAM.
// Latency: response valid WAIT_CYCLES+1 edges after acceptance, counting the accepting edge.
// Backpressure: no new request while busy; response held stable until rsp_ready_i.
// Ports: clk_i, rst_i (async, active-high), bus (dmem_if.slave).
// Build option DMEM_MISALIGN_ERR_EN: misaligned half/word accesses return err=1, rdata=0,
// and never write the RAM.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_we;
    logic [AW+1:0]         r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic [31:0]           r_mem [DEPTH_WORDS];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_in_idle;
    logic                  w_we;
    logic [AW+1:0]         w_addr;
    logic [31:0]           w_wdata;
    logic [2:0]            w_funct3;
    logic [AW-1:0]         w_idx;
    logic [31:0]           w_rword;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_sh;
    logic [31:0]           w_rdata;
    logic                  w_err;
    logic [31:0]           w_rsp_rdata;
    logic                  w_ram_we;
    logic                  w_unused_addr;

    // Address bits above the RAM span are ignored so accesses wrap.
    assign w_unused_addr = ^bus.req_addr_i[31:AW+2];

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_accept     = w_in_idle & r_req_ready & bus.req_valid_i;
    // With zero wait the RAM access happens on the accepting edge itself.
    assign w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == '0)) ||
                          (w_accept && (WAIT_CYCLES == 0));

    // Zero-wait transactions are serviced before the request is latched, so use the live bus.
    assign w_we     = w_in_idle ? bus.req_we_i              : r_we;
    assign w_addr   = w_in_idle ? bus.req_addr_i[AW+1:0]    : r_addr;
    assign w_wdata  = w_in_idle ? bus.req_wdata_i           : r_wdata;
    assign w_funct3 = w_in_idle ? bus.req_funct3_i          : r_funct3;
    assign w_idx    = w_addr[AW+1:2];
    assign w_rword  = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_addr   (w_addr[1:0]),
        .i_funct3 (w_funct3),
        .i_wdata  (w_wdata),
        .i_rword  (w_rword),
        .o_be     (w_be),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_rdata),
        .o_err    (w_err)
    );

    assign w_rsp_rdata = (w_we | w_err) ? 32'd0 : w_rdata;
    // rst_i gating keeps a store from landing if reset arrives on the RESP entry edge.
    assign w_ram_we    = w_enter_resp & w_we & ~w_err & ~rst_i;

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_we        <= bus.req_we_i;
                        r_addr      <= bus.req_addr_i[AW+1:0];
                        r_wdata     <= bus.req_wdata_i;
                        r_funct3    <= bus.req_funct3_i;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rsp_rdata;
                            r_err       <= w_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_rsp_rdata;
                        r_err       <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = r_req_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rdata;
    assign bus.rsp_err_o   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder (WAIT_CYCLES=2, DEPTH_WORDS=1024).
// Table of load/store vectors plus hand-written back-pressure and mid-transaction reset cases.
// Expectations for misaligned accesses follow DMEM_MISALIGN_ERR_EN.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int WAIT_CYCLES = 2;
    localparam int EXP_LAT     = WAIT_CYCLES + 1;
    localparam int BOUND       = 50;

    logic clk;
    logic rst;
    dmem_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Waits for req_ready, issues one request, and waits for the response.
    // lat counts edges from the accepting edge (inclusive) to the one raising rsp_valid.
    // The response is consumed only if rsp_ready_i is already high.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        n   = 0;
        while (bus.req_ready_o !== 1'b1 && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        if (bus.req_ready_o !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_funct3_i = f3;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (bus.rsp_valid_o !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        if (bus.rsp_valid_o !== 1'b1) ok = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int          lat;
        bit          ok;
        logic [31:0] held;
        logic [31:0] exp_w102;
        logic        exp_e102;
        logic [31:0] exp_h103;

`ifdef DMEM_MISALIGN_ERR_EN
        exp_w102 = 32'h0000_0000; exp_e102 = 1'b1; exp_h103 = 32'h0000_0000;
`else
        exp_w102 = 32'hABCD_8044; exp_e102 = 1'b0; exp_h103 = 32'hFFFF_ABCD;
`endif

        vecs[0]  = mk("sw_100_deadbeef", 1, 32'h100,  32'hDEADBEEF, F3_W,  32'h0,          0);
        vecs[1]  = mk("lw_100",          0, 32'h100,  32'h0,        F3_W,  32'hDEADBEEF,   0);
        vecs[2]  = mk("sw_100_11223344", 1, 32'h100,  32'h11223344, F3_W,  32'h0,          0);
        vecs[3]  = mk("sb_101_80",       1, 32'h101,  32'hFFFFFF80, F3_B,  32'h0,          0);
        vecs[4]  = mk("lb_101",          0, 32'h101,  32'h0,        F3_B,  32'hFFFFFF80,   0);
        vecs[5]  = mk("lbu_101",         0, 32'h101,  32'h0,        F3_BU, 32'h00000080,   0);
        vecs[6]  = mk("lw_100_after_sb", 0, 32'h100,  32'h0,        F3_W,  32'h11228044,   0);
        vecs[7]  = mk("sh_102_abcd",     1, 32'h102,  32'h5555ABCD, F3_H,  32'h0,          0);
        vecs[8]  = mk("lh_102",          0, 32'h102,  32'h0,        F3_H,  32'hFFFFABCD,   0);
        vecs[9]  = mk("lhu_102",         0, 32'h102,  32'h0,        F3_HU, 32'h0000ABCD,   0);
        vecs[10] = mk("lhu_100_low",     0, 32'h100,  32'h0,        F3_HU, 32'h00008044,   0);
        vecs[11] = mk("lb_103",          0, 32'h103,  32'h0,        F3_B,  32'hFFFFFFAB,   0);
        vecs[12] = mk("lw_1100_wrap",    0, 32'h1100, 32'h0,        F3_W,  32'hABCD8044,   0);
        vecs[13] = mk("sw_104_7f7f",     1, 32'h104,  32'h00007F7F, F3_W,  32'h0,          0);
        vecs[14] = mk("lh_104_pos",      0, 32'h104,  32'h0,        F3_H,  32'h00007F7F,   0);
        vecs[15] = mk("lw_102_misalign", 0, 32'h102,  32'h0,        F3_W,  exp_w102,  exp_e102);
        vecs[16] = mk("lh_103_misalign", 0, 32'h103,  32'h0,        F3_H,  exp_h103,  exp_e102);
        vecs[17] = mk("sw_200_55",       1, 32'h200,  32'h00000055, F3_W,  32'h0,          0);

        rst = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_funct3_i = '0;
        bus.rsp_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        check("reset_rsp_err",   {31'd0, bus.rsp_err_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, lat, ok);
            check({vecs[i].name, "_handshake"}, {31'd0, ok}, 32'd1);
            check({vecs[i].name, "_latency"}, lat, EXP_LAT);
            check({vecs[i].name, "_rdata"}, bus.rsp_rdata_o, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, {31'd0, bus.rsp_err_o}, {31'd0, vecs[i].exp_err});
            @(posedge clk); #1;
        end

        // Back-pressure: response must hold for 5 cycles with no new request accepted.
        bus.rsp_ready_i = 1'b0;
        issue(1'b0, 32'h100, 32'h0, F3_W, lat, ok);
        check("bp_handshake", {31'd0, ok}, 32'd1);
        held = bus.rsp_rdata_o;
        check("bp_first_rdata", held, 32'hABCD8044);
        bus.req_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
            check("bp_hold_rdata", bus.rsp_rdata_o, 32'hABCD8044);
            check("bp_hold_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("bp_release_req_ready", {31'd0, bus.req_ready_o}, 32'd1);

        // Reset during WAIT of a store: store is dropped, outputs cleared.
        lat = 0;
        while (bus.req_ready_o !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        check("rst_pre_ready", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b1;
        bus.req_addr_i   = 32'h200;
        bus.req_wdata_i  = 32'h1;
        bus.req_funct3_i = F3_W;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check("rst_in_wait_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("rst_mid_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_mid_err", {31'd0, bus.rsp_err_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        rst = 1'b0;
        issue(1'b0, 32'h200, 32'h0, F3_W, lat, ok);
        check("rst_after_handshake", {31'd0, ok}, 32'd1);
        check("rst_after_latency", lat, EXP_LAT);
        check("rst_store_dropped", bus.rsp_rdata_o, 32'h00000055);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
